// File: rtl/stage_memory.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : stage_memory
// Description : Pipeline MEM stage. Non-memory ops pass straight through to the
//               MEM/WB registers; legal loads/stores run a two-state handshake
//               with data memory while stalling upstream; misaligned or
//               malformed accesses retire in one cycle with mem_err set.
// Revision    : 1.0  initial release
// ============================================================================
module stage_memory (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_data,
  input  logic        mem_rd_en,
  input  logic        mem_wr_en,
  input  logic [2:0]  funct3,
  input  logic [1:0]  write_back_sel_in,
  input  logic [31:0] pc_in,
  input  logic [4:0]  rd_addr_in,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        valid_out,
  output logic [31:0] data_mem_rd_data,
  output logic [31:0] alu_result_out,
  output logic [31:0] pc_out,
  output logic [1:0]  write_back_sel_out,
  output logic [4:0]  rd_addr_out,
  output logic        mem_err
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [3:0]  dmem_be_q, dmem_be_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  offset_q, offset_d;
  logic        valid_out_q, valid_out_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [1:0]  wb_sel_q, wb_sel_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic        mem_err_q, mem_err_d;

  logic [1:0]  offset;
  logic        size_ok;
  logic        access_legal;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;

  // Decode the incoming access: legality check and store lane formatting.
  // Unsigned sizes only exist for loads, so BU/HU with a store is illegal.
  always_comb begin
    offset  = alu_result[1:0];
    size_ok = 1'b0;
    case (funct3)
      F3_B:    size_ok = 1'b1;
      F3_H:    size_ok = !offset[0];
      F3_W:    size_ok = (offset == 2'b00);
      F3_BU:   size_ok = mem_rd_en;
      F3_HU:   size_ok = mem_rd_en && !offset[0];
      default: size_ok = 1'b0;
    endcase
    access_legal = (mem_rd_en ^ mem_wr_en) && size_ok;

    fmt_be    = 4'b1111;
    fmt_wdata = rs2_data;
    case (funct3[1:0])
      2'b00: begin
        fmt_be    = 4'b0001 << offset;
        fmt_wdata = {4{rs2_data[7:0]}};
      end
      2'b01: begin
        fmt_be    = 4'b0011 << offset;
        fmt_wdata = {2{rs2_data[15:0]}};
      end
      default: begin
        fmt_be    = 4'b1111;
        fmt_wdata = rs2_data;
      end
    endcase
  end

  // Extract and extend the addressed lane of the returned read word.
  always_comb begin
    sel_byte  = dmem_rdata[{offset_q, 3'b000} +: 8];
    sel_half  = offset_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_data = dmem_rdata;
    case (funct3_q)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_BU:   load_data = {24'h0, sel_byte};
      F3_HU:   load_data = {16'h0, sel_half};
      default: load_data = dmem_rdata;
    endcase
  end

  // Next-state, memory request and MEM/WB retirement logic.
  always_comb begin
    state_d      = state_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_be_d    = dmem_be_q;
    funct3_d     = funct3_q;
    offset_d     = offset_q;
    valid_out_d  = 1'b0;
    rd_data_d    = rd_data_q;
    alu_out_d    = alu_out_q;
    pc_out_d     = pc_out_q;
    wb_sel_d     = wb_sel_q;
    rd_addr_d    = rd_addr_q;
    mem_err_d    = mem_err_q;
    stall        = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_in) begin
          if (mem_rd_en || mem_wr_en) begin
            if (access_legal) begin
              state_d      = ACCESS;
              dmem_req_d   = 1'b1;
              dmem_we_d    = mem_wr_en;
              dmem_addr_d  = {alu_result[31:2], 2'b00};
              dmem_be_d    = fmt_be;
              dmem_wdata_d = mem_wr_en ? fmt_wdata : 32'h0;
              funct3_d     = funct3;
              offset_d     = offset;
              stall        = 1'b1;
            end else begin
              valid_out_d  = 1'b1;
              mem_err_d    = 1'b1;
              rd_data_d    = 32'h0;
            end
          end else begin
            valid_out_d    = 1'b1;
            mem_err_d      = 1'b0;
            rd_data_d      = 32'h0;
          end
        end
      end
      ACCESS: begin
        // Inputs are held by upstream while stalled, so sideband is read live.
        stall = !dmem_ready;
        if (dmem_ready) begin
          state_d     = IDLE;
          dmem_req_d  = 1'b0;
          valid_out_d = 1'b1;
          mem_err_d   = 1'b0;
          rd_data_d   = dmem_we_q ? 32'h0 : load_data;
        end
      end
      default: state_d = IDLE;
    endcase

    if (valid_out_d) begin
      alu_out_d = alu_result;
      pc_out_d  = pc_in;
      wb_sel_d  = write_back_sel_in;
      rd_addr_d = rd_addr_in;
    end

    if (reset) begin
      stall = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'h0;
      dmem_wdata_q <= 32'h0;
      dmem_be_q    <= 4'b0000;
      funct3_q     <= 3'b000;
      offset_q     <= 2'b00;
      valid_out_q  <= 1'b0;
      rd_data_q    <= 32'h0;
      alu_out_q    <= 32'h0;
      pc_out_q     <= 32'h0;
      wb_sel_q     <= 2'b00;
      rd_addr_q    <= 5'd0;
      mem_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_be_q    <= dmem_be_d;
      funct3_q     <= funct3_d;
      offset_q     <= offset_d;
      valid_out_q  <= valid_out_d;
      rd_data_q    <= rd_data_d;
      alu_out_q    <= alu_out_d;
      pc_out_q     <= pc_out_d;
      wb_sel_q     <= wb_sel_d;
      rd_addr_q    <= rd_addr_d;
      mem_err_q    <= mem_err_d;
    end
  end

  assign dmem_req           = dmem_req_q;
  assign dmem_we            = dmem_we_q;
  assign dmem_addr          = dmem_addr_q;
  assign dmem_wdata         = dmem_wdata_q;
  assign dmem_be            = dmem_be_q;
  assign valid_out          = valid_out_q;
  assign data_mem_rd_data   = rd_data_q;
  assign alu_result_out     = alu_out_q;
  assign pc_out             = pc_out_q;
  assign write_back_sel_out = wb_sel_q;
  assign rd_addr_out        = rd_addr_q;
  assign mem_err            = mem_err_q;

endmodule
`default_nettype wire

// File: tb/tb_stage_memory.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_stage_memory
// Description : Scoreboard bench for stage_memory. The driver pushes the
//               expected MEM/WB result when it issues an instruction; a
//               negedge monitor pops and compares on every valid_out pulse.
// Revision    : 1.0  initial release
// ============================================================================
module tb_stage_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] alu_result;
  logic [31:0] rs2_data;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [2:0]  funct3;
  logic [1:0]  write_back_sel_in;
  logic [31:0] pc_in;
  logic [4:0]  rd_addr_in;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        valid_out;
  logic [31:0] data_mem_rd_data;
  logic [31:0] alu_result_out;
  logic [31:0] pc_out;
  logic [1:0]  write_back_sel_out;
  logic [4:0]  rd_addr_out;
  logic        mem_err;

  stage_memory dut (
    .clk                (clk),
    .reset              (reset),
    .valid_in           (valid_in),
    .alu_result         (alu_result),
    .rs2_data           (rs2_data),
    .mem_rd_en          (mem_rd_en),
    .mem_wr_en          (mem_wr_en),
    .funct3             (funct3),
    .write_back_sel_in  (write_back_sel_in),
    .pc_in              (pc_in),
    .rd_addr_in         (rd_addr_in),
    .stall              (stall),
    .dmem_req           (dmem_req),
    .dmem_we            (dmem_we),
    .dmem_addr          (dmem_addr),
    .dmem_wdata         (dmem_wdata),
    .dmem_be            (dmem_be),
    .dmem_ready         (dmem_ready),
    .dmem_rdata         (dmem_rdata),
    .valid_out          (valid_out),
    .data_mem_rd_data   (data_mem_rd_data),
    .alu_result_out     (alu_result_out),
    .pc_out             (pc_out),
    .write_back_sel_out (write_back_sel_out),
    .rd_addr_out        (rd_addr_out),
    .mem_err            (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        chk_data;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [1:0]  wb;
    logic [4:0]  rd;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every valid_out pulse must match the oldest outstanding entry.
  always @(negedge clk) begin
    if (!reset && valid_out) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid_out: got valid_out=1 at cycle %0d expected no pulse", cyc);
      end else begin
        mon_e = q.pop_front();
        chk("latency_cycle", cyc, mon_e.cyc);
        chk("mem_err", {31'h0, mem_err}, {31'h0, mon_e.err});
        chk("alu_result_out", alu_result_out, mon_e.alu);
        chk("pc_out", pc_out, mon_e.pc);
        chk("write_back_sel_out", {30'h0, write_back_sel_out}, {30'h0, mon_e.wb});
        chk("rd_addr_out", {27'h0, rd_addr_out}, {27'h0, mon_e.rd});
        if (mon_e.chk_data) chk("data_mem_rd_data", data_mem_rd_data, mon_e.data);
      end
    end
  end

  // Issue one instruction, play the memory side, and queue its expected result.
  task automatic do_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] pc,
                       input int waits, input logic [31:0] rdata, input logic mem,
                       input logic err, input logic chk_d, input logic [31:0] exp_d,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd);
    exp_t e;
    valid_in          = 1'b1;
    mem_rd_en         = rd;
    mem_wr_en         = wr;
    funct3            = f3;
    alu_result        = addr;
    rs2_data          = rs2;
    pc_in             = pc;
    write_back_sel_in = pc[3:2];
    rd_addr_in        = pc[8:4];
    e.data     = exp_d;
    e.chk_data = chk_d;
    e.alu      = addr;
    e.pc       = pc;
    e.wb       = pc[3:2];
    e.rd       = pc[8:4];
    e.err      = err;
    e.cyc      = cyc + 1 + (mem ? 1 + waits : 0);
    q.push_back(e);
    @(negedge clk);
    chk({tag, "_stall_at_accept"}, {31'h0, stall}, {31'h0, mem});
    chk({tag, "_no_req_at_accept"}, {31'h0, dmem_req}, 32'h0);
    @(posedge clk);
    #1;
    if (mem) begin
      for (int w = 0; w <= waits; w++) begin
        dmem_ready = (w == waits);
        dmem_rdata = (w == waits) ? rdata : 32'h5A5A_0000 + w;
        @(negedge clk);
        chk({tag, "_dmem_req"}, {31'h0, dmem_req}, 32'h1);
        chk({tag, "_dmem_addr"}, dmem_addr, {addr[31:2], 2'b00});
        chk({tag, "_dmem_we"}, {31'h0, dmem_we}, {31'h0, wr});
        chk({tag, "_stall_access"}, {31'h0, stall}, {31'h0, (w != waits)});
        if (wr) begin
          chk({tag, "_dmem_be"}, {28'h0, dmem_be}, {28'h0, exp_be});
          chk({tag, "_dmem_wdata"}, dmem_wdata, exp_wd);
        end
        @(posedge clk);
        #1;
      end
      dmem_ready = 1'b0;
    end
    valid_in  = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; alu_result = 32'h0; rs2_data = 32'h0;
    mem_rd_en = 1'b0; mem_wr_en = 1'b0; funct3 = 3'b000; write_back_sel_in = 2'b00;
    pc_in = 32'h0; rd_addr_in = 5'd0; dmem_ready = 1'b0; dmem_rdata = 32'h0;

    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid_out", {31'h0, valid_out}, 32'h0);
    chk("rst_mem_err", {31'h0, mem_err}, 32'h0);
    chk("rst_dmem_req", {31'h0, dmem_req}, 32'h0);
    chk("rst_dmem_we", {31'h0, dmem_we}, 32'h0);
    chk("rst_dmem_be", {28'h0, dmem_be}, 32'h0);
    chk("rst_dmem_addr", dmem_addr, 32'h0);
    chk("rst_dmem_wdata", dmem_wdata, 32'h0);
    chk("rst_rd_data", data_mem_rd_data, 32'h0);
    chk("rst_alu_out", alu_result_out, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_wb_sel", {30'h0, write_back_sel_out}, 32'h0);
    chk("rst_rd_addr", {27'h0, rd_addr_out}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // A stray dmem_ready in IDLE must not start or complete anything.
    dmem_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_ready_no_req", {31'h0, dmem_req}, 32'h0);
      chk("idle_ready_no_valid", {31'h0, valid_out}, 32'h0);
    end
    @(posedge clk);
    #1;
    dmem_ready = 1'b0;

    //     tag       rd    wr    f3      addr          rs2           pc      w  rdata         mem   err   chkd  exp_d         be       wdata
    do_op("alu",    1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0,        32'h40, 0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        4'h0,    32'h0);
    do_op("lb",     1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h44, 0, 32'h80FF_0000, 1'b1, 1'b0, 1'b1, 32'hFFFF_FF80, 4'h0,    32'h0);
    do_op("sh",     1'b0, 1'b1, 3'b001, 32'h0000_0022, 32'h0000_BEEF, 32'h48, 3, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0,        4'b1100, 32'hBEEF_BEEF);
    do_op("lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0,        32'h4C, 0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        4'h0,    32'h0);
    do_op("lhu",    1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'h0,        32'h50, 0, 32'h9ABC_0000, 1'b1, 1'b0, 1'b1, 32'h0000_9ABC, 4'h0,    32'h0);
    do_op("sb",     1'b0, 1'b1, 3'b000, 32'h0000_0045, 32'h1234_56A5, 32'h54, 1, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0,        4'b0010, 32'hA5A5_A5A5);
    do_op("sw",     1'b0, 1'b1, 3'b010, 32'h0000_0080, 32'hDEAD_BEEF, 32'h58, 0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0,        4'b1111, 32'hDEAD_BEEF);
    do_op("lh",     1'b1, 1'b0, 3'b001, 32'h0000_0012, 32'h0,        32'h5C, 0, 32'h8001_1234, 1'b1, 1'b0, 1'b1, 32'hFFFF_8001, 4'h0,    32'h0);
    do_op("lbu",    1'b1, 1'b0, 3'b100, 32'h0000_0001, 32'h0,        32'h60, 2, 32'h0000_F000, 1'b1, 1'b0, 1'b1, 32'h0000_00F0, 4'h0,    32'h0);
    do_op("lw",     1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0,        32'h64, 1, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D, 4'h0,    32'h0);
    do_op("both",   1'b1, 1'b1, 3'b010, 32'h0000_0000, 32'h0,        32'h68, 0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        4'h0,    32'h0);
    do_op("ld_011", 1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h6C, 0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        4'h0,    32'h0);
    do_op("st_100", 1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h0,        32'h70, 0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        4'h0,    32'h0);
    do_op("sh_odd", 1'b0, 1'b1, 3'b001, 32'h0000_0023, 32'h0,        32'h74, 0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        4'h0,    32'h0);

    // Reset in the middle of an outstanding LW: the access is abandoned.
    valid_in = 1'b1; mem_rd_en = 1'b1; funct3 = 3'b010; alu_result = 32'h0000_0010;
    pc_in = 32'h78; write_back_sel_in = 2'b10; rd_addr_in = 5'd7;
    @(posedge clk);
    #1;
    dmem_ready = 1'b0;
    @(negedge clk);
    chk("rstacc_req_before", {31'h0, dmem_req}, 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rstacc_stall_in_reset", {31'h0, stall}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0; valid_in = 1'b0; mem_rd_en = 1'b0;
    dmem_ready = 1'b1; dmem_rdata = 32'h1111_2222;
    repeat (2) begin
      @(negedge clk);
      chk("rstacc_req_after", {31'h0, dmem_req}, 32'h0);
      chk("rstacc_no_valid", {31'h0, valid_out}, 32'h0);
      @(posedge clk);
      #1;
    end
    dmem_ready = 1'b0;

    // Back in IDLE: a plain ALU op retires with single-cycle latency.
    do_op("alu_post", 1'b0, 1'b0, 3'b000, 32'h0000_5555, 32'h0, 32'h80, 0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stage_memory.md
STAGE_MEMORY -- requirements
Module: stage_memory

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 valid_in  in  1  instruction present on stage inputs.
REQ-004 alu_result  in  32  effective address, or ALU value for non-memory ops.
REQ-005 rs2_data  in  32  store data.
REQ-006 mem_rd_en / mem_wr_en  in  1 each  load / store request.
REQ-007 funct3  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 write_back_sel_in  in  2, pc_in  in  32, rd_addr_in  in  5  sideband, forwarded unchanged.
REQ-009 stall  out  1  combinational; upstream holds all inputs stable while high.
REQ-010 dmem_req  out  1, dmem_we  out  1, dmem_addr  out  32 (word-aligned), dmem_wdata  out  32, dmem_be  out  4  data memory request.
REQ-011 dmem_ready  in  1, dmem_rdata  in  32  memory completion and read word.
REQ-012 valid_out  out  1, data_mem_rd_data  out  32, alu_result_out  out  32, pc_out  out  32, write_back_sel_out  out  2, rd_addr_out  out  5, mem_err  out  1  registered MEM/WB outputs.

Function
REQ-013 The FSM SHALL have two states: IDLE and ACCESS.
REQ-014 IDLE, valid_in=1, no memory op: register the sideband and alu_result into the outputs; valid_out=1 on the next cycle; stall=0.
REQ-015 IDLE, valid_in=1, exactly one of rd/wr enabled, access legal: latch the request, go to ACCESS, stall=1.
REQ-016 ACCESS SHALL assert dmem_req=1 with stable addr, we, be and wdata until dmem_ready=1 is sampled.
REQ-017 ACCESS: stall = !dmem_ready; on dmem_ready=1, register the outputs, set valid_out=1 on the next cycle, and return to IDLE.
REQ-018 Minimum memory-op latency: accept at T, req at T+1 (ready=1), valid_out at T+2; each wait cycle adds one cycle.
REQ-019 dmem_addr = {alu_result[31:2], 2'b00}.
REQ-020 Stores:
- SB: be = 0001 << addr[1:0]; wdata = byte replicated x4.
- SH: be = 0011 << addr[1:0]; wdata = half replicated x2.
- SW: be = 1111.
REQ-021 Loads select the byte or half at addr[1:0] from dmem_rdata:
- B and H are sign-extended.
- BU and HU are zero-extended.
- W passes the word through.
REQ-022 Stores SHALL drive data_mem_rd_data = 0.
REQ-023 Illegal access (any one of the following): no dmem_req is issued; one-cycle pass-through with mem_err=1 and valid_out=1.
- H/HU with addr[0]=1.
- W with addr[1:0]!=0.
- Load funct3 of 011, 110 or 111.
- Store funct3 other than 000, 001 or 010.
- mem_rd_en and mem_wr_en both high.
REQ-024 mem_err SHALL be 0 on every other valid_out.
REQ-025 valid_out SHALL be a one-cycle pulse per instruction; with no completion it is 0, and the data outputs hold their last values.
REQ-026 dmem_ready while in IDLE SHALL be ignored.
REQ-027 valid_in=0 in IDLE SHALL produce valid_out=0 next cycle and no state change.

Reset
REQ-028 reset=1 SHALL force:
- state IDLE.
- dmem_req, dmem_we, valid_out and mem_err to 0.
- dmem_be to 0000.
- all data, address and sideband outputs to 0.
REQ-029 Reset during ACCESS SHALL abandon the access: dmem_req=0 on the next cycle, no valid_out, and a subsequent dmem_ready is ignored.
REQ-030 stall SHALL be 0 while reset=1.

Verification
REQ-031 LB at addr 0x103, dmem_rdata=0x80FF_0000, ready immediate -> dmem_addr=0x100; valid_out at T+2; data_mem_rd_data=0xFFFF_FF80.
REQ-032 SH at addr 0x22, rs2_data=0x0000_BEEF, ready after 3 wait cycles -> be=1100, wdata=0xBEEF_BEEF, stall high 4 cycles, valid_out once.
REQ-033 LW at addr 0x6 -> no dmem_req, mem_err=1 and valid_out=1 next cycle, stall=0.
REQ-034 Non-memory op, alu_result=0x1234, pc_in=0x40 -> valid_out next cycle, alu_result_out=0x1234, pc_out=0x40.
REQ-035 LHU at addr 0x2, dmem_rdata=0x9ABC_0000 -> data_mem_rd_data=0x0000_9ABC.
REQ-036 LW accepted, reset=1 during ACCESS wait, then dmem_ready=1 -> dmem_req=0 after reset, valid_out stays 0, FSM in IDLE.
